// File: rtl/pio_in_debounce.sv
`default_nettype none
// ============================================================================
// Module   : pio_in_debounce
// Purpose  : Avalon-MM input PIO with synchroniser, per-bit debounce, sticky
//            edge capture and maskable level interrupt.
// Revision : 1.0
// ============================================================================
module pio_in_debounce #(
   parameter int WIDTH          = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_W     = 16,
   parameter int DEBOUNCE_RESET = 50000,
   parameter int EDGE_TYPE      = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [DEBOUNCE_W-1:0] c_PERIOD_RST = DEBOUNCE_W'(DEBOUNCE_RESET);
   localparam logic [DEBOUNCE_W-1:0] c_CNT_ONE    = DEBOUNCE_W'(1);
   localparam logic [1:0]            c_ADDR_DATA   = 2'd0;
   localparam logic [1:0]            c_ADDR_PERIOD = 2'd1;
   localparam logic [1:0]            c_ADDR_MASK   = 2'd2;
   localparam logic [1:0]            c_ADDR_EDGE   = 2'd3;

   logic [WIDTH-1:0]      sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]      w_sync;
   logic [WIDTH-1:0]      stable_q, stable_d, stable_dly_q;
   logic [DEBOUNCE_W-1:0] cnt_q [WIDTH];
   logic [DEBOUNCE_W-1:0] cnt_d [WIDTH];
   logic [DEBOUNCE_W-1:0] period_q, period_d;
   logic [WIDTH-1:0]      mask_q, mask_d;
   logic [WIDTH-1:0]      edge_q, edge_d;
   logic [31:0]           readdata_q, readdata_d;
   logic                  irq_q, irq_d;
   logic [WIDTH-1:0]      w_rise, w_fall, w_ev, w_clr;
   logic                  w_wr;
   logic                  w_unused_wd;

   assign w_sync      = sync_q[SYNC_STAGES-1];
   assign w_wr        = chipselect & write;
   assign w_unused_wd = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Using >= lets a lowered period release a count that already passed it.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (w_sync[i] != stable_q[i]) begin
            if (cnt_q[i] >= period_q) stable_d[i] = w_sync[i];
            else                      cnt_d[i]    = cnt_q[i] + c_CNT_ONE;
         end
      end
   end

   assign w_rise = stable_q & ~stable_dly_q;
   assign w_fall = ~stable_q & stable_dly_q;

   always_comb begin
      case (EDGE_TYPE)
         0:       w_ev = w_rise;
         1:       w_ev = w_fall;
         default: w_ev = w_rise | w_fall;
      endcase
   end

   always_comb begin
      period_d = period_q;
      mask_d   = mask_q;
      w_clr    = '0;
      if (w_wr && (address == c_ADDR_PERIOD)) period_d = writedata[DEBOUNCE_W-1:0];
      if (w_wr && (address == c_ADDR_MASK))   mask_d   = writedata[WIDTH-1:0];
      if (w_wr && (address == c_ADDR_EDGE))   w_clr    = writedata[WIDTH-1:0];
      // New events override a simultaneous clear.
      edge_d = (edge_q & ~w_clr) | w_ev;
      irq_d  = |(edge_q & mask_q);
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         c_ADDR_DATA:   readdata_d[WIDTH-1:0]      = stable_q;
         c_ADDR_PERIOD: readdata_d[DEBOUNCE_W-1:0] = period_q;
         c_ADDR_MASK:   readdata_d[WIDTH-1:0]      = mask_q;
         c_ADDR_EDGE:   readdata_d[WIDTH-1:0]      = edge_q;
         default:       readdata_d                 = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_q     <= '0;
         stable_dly_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
         period_q     <= c_PERIOD_RST;
         mask_q       <= '0;
         edge_q       <= '0;
         readdata_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
         period_q     <= period_d;
         mask_q       <= mask_d;
         edge_q       <= edge_d;
         readdata_q   <= readdata_d;
         irq_q        <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
`default_nettype wire
